// File: rtl/gate_result_skid.sv
// gate_result_skid
//   Registered output stage behind the gate array. Each accepted transfer
//   picks one of the seven gate result buses using op_sel_in. The chosen
//   result, the op code and an illegal-op flag are stored as one entry.
//   A 2-entry skid buffer (main + skid) holds the entries, so the stage runs
//   at one transfer per cycle and still accepts the single beat already in
//   flight when the downstream side stalls. A wrapping counter tracks the
//   number of results delivered downstream.
//
// Ports
//   clk_in, rst_in        clock; asynchronous active-high reset
//   y_*_in                gate result buses (AND, OR, NOT, XOR, XNOR, NAND, NOR)
//   op_sel_in             0..6 select a result; 7 is illegal (y=0, err=1)
//   valid_in / ready_out  upstream handshake
//   y_out, op_out, err_out, valid_out / ready_in   downstream handshake
//   count_out             completed output transfers, wraps
//   state_out             buffer state {main_full, skid_full} for debug
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high. The source holds valid and its data stable until the beat is taken.
// ready_out depends only on registered state (and reset), never on valid_in
// or ready_in.

module gate_result_skid #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [DATA_WIDTH-1:0]  y_and_in,
  input  logic [DATA_WIDTH-1:0]  y_or_in,
  input  logic [DATA_WIDTH-1:0]  y_not_in,
  input  logic [DATA_WIDTH-1:0]  y_xor_in,
  input  logic [DATA_WIDTH-1:0]  y_xnor_in,
  input  logic [DATA_WIDTH-1:0]  y_nand_in,
  input  logic [DATA_WIDTH-1:0]  y_nor_in,
  input  logic [2:0]             op_sel_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [DATA_WIDTH-1:0]  y_out,
  output logic [2:0]             op_out,
  output logic                   err_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic [1:0]             state_out
);

  // State encoding is {main_full, skid_full}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] skid_y;
  logic [2:0]            skid_op;
  logic                  skid_err;

  logic [DATA_WIDTH-1:0] sel_y;
  logic                  sel_err;
  logic                  accept;
  logic                  emit;

  always_comb begin
    sel_y   = '0;
    sel_err = 1'b0;
    case (op_sel_in)
      3'd0:    sel_y = y_and_in;
      3'd1:    sel_y = y_or_in;
      3'd2:    sel_y = y_not_in;
      3'd3:    sel_y = y_xor_in;
      3'd4:    sel_y = y_xnor_in;
      3'd5:    sel_y = y_nand_in;
      3'd6:    sel_y = y_nor_in;
      default: sel_err = 1'b1;
    endcase
  end

  // rst_in term keeps ready low during reset, while the async clear has
  // already emptied both entries.
  assign ready_out = (state != FULL) && !rst_in;
  assign valid_out = (state != EMPTY);
  assign accept    = valid_in && ready_out;
  assign emit      = valid_out && ready_in;
  assign state_out = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= EMPTY;
      y_out     <= '0;
      op_out    <= '0;
      err_out   <= 1'b0;
      skid_y    <= '0;
      skid_op   <= '0;
      skid_err  <= 1'b0;
      count_out <= '0;
    end else begin
      if (emit) begin
        count_out <= count_out + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            y_out   <= sel_y;
            op_out  <= op_sel_in;
            err_out <= sel_err;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            // Main drains and reloads in the same edge.
            y_out   <= sel_y;
            op_out  <= op_sel_in;
            err_out <= sel_err;
          end else if (accept) begin
            // Main is stalled; park the new beat in the skid entry.
            skid_y   <= sel_y;
            skid_op  <= op_sel_in;
            skid_err <= sel_err;
            state    <= FULL;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            y_out   <= skid_y;
            op_out  <= skid_op;
            err_out <= skid_err;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_result_skid.sv
module tb_gate_result_skid;

  logic        clk_in;
  logic        rst_in;
  logic [7:0]  a, b;
  logic [2:0]  op_sel_in;
  logic        valid_in;
  logic        ready_in;
  logic        ready_out, err_out, valid_out;
  logic [7:0]  y_out;
  logic [2:0]  op_out;
  logic [15:0] count_out;
  logic [1:0]  state_out;

  // Second instance with a 4-bit counter, same stimulus, for wrap checks.
  logic        ready_c4, err_c4, valid_c4;
  logic [7:0]  y_c4;
  logic [2:0]  op_c4;
  logic [3:0]  count_c4;
  logic [1:0]  state_c4;

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-computed gate results for a=8'hA5, b=8'h0F, index = op.
  logic [7:0] exp_tab [0:7];

  gate_result_skid #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .y_and_in(a & b), .y_or_in(a | b), .y_not_in(~a), .y_xor_in(a ^ b),
    .y_xnor_in(~(a ^ b)), .y_nand_in(~(a & b)), .y_nor_in(~(a | b)),
    .op_sel_in(op_sel_in), .valid_in(valid_in), .ready_out(ready_out),
    .y_out(y_out), .op_out(op_out), .err_out(err_out), .valid_out(valid_out),
    .ready_in(ready_in), .count_out(count_out), .state_out(state_out)
  );

  gate_result_skid #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_c4 (
    .clk_in(clk_in), .rst_in(rst_in),
    .y_and_in(a & b), .y_or_in(a | b), .y_not_in(~a), .y_xor_in(a ^ b),
    .y_xnor_in(~(a ^ b)), .y_nand_in(~(a & b)), .y_nor_in(~(a | b)),
    .op_sel_in(op_sel_in), .valid_in(valid_in), .ready_out(ready_c4),
    .y_out(y_c4), .op_out(op_c4), .err_out(err_c4), .valid_out(valid_c4),
    .ready_in(ready_in), .count_out(count_c4), .state_out(state_c4)
  );

  // Clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic v);
    op_sel_in = op;
    valid_in  = v;
  endtask

  initial begin
    exp_tab[0] = 8'h05; exp_tab[1] = 8'hAF; exp_tab[2] = 8'h5A; exp_tab[3] = 8'hAA;
    exp_tab[4] = 8'h55; exp_tab[5] = 8'hFA; exp_tab[6] = 8'h50; exp_tab[7] = 8'h00;

    rst_in = 1'b1; a = 8'hA5; b = 8'h0F;
    op_sel_in = 3'd0; valid_in = 1'b0; ready_in = 1'b1;

    // Reset state
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 0);
    check("rst_count", count_out, 0);
    check("rst_y", y_out, 0);
    tick(); tick();
    rst_in = 1'b0;
    #1;
    check("post_rst_ready", ready_out, 1);
    check("post_rst_state", state_out, 2'b00);

    // Single XOR transfer: A5 ^ 0F = AA
    drive(3'd3, 1'b1);
    tick();
    drive(3'd0, 1'b0);
    check("xor_valid", valid_out, 1);
    check("xor_y", y_out, 8'hAA);
    check("xor_op", op_out, 3);
    check("xor_err", err_out, 0);
    check("xor_count_pre", count_out, 0);
    tick();
    check("xor_count", count_out, 1);
    check("xor_empty", valid_out, 0);

    // Stream ops 0..6 back-to-back at full rate
    for (int i = 0; i < 7; i++) begin
      drive(i[2:0], 1'b1);
      check($sformatf("stream_ready_%0d", i), ready_out, 1);
      tick();
      check($sformatf("stream_valid_%0d", i), valid_out, 1);
      check($sformatf("stream_y_%0d", i), y_out, exp_tab[i]);
      check($sformatf("stream_op_%0d", i), op_out, i);
    end
    drive(3'd0, 1'b0);
    tick();
    check("stream_count", count_out, 8);
    check("stream_drained", valid_out, 0);

    // Back-pressure: three items with ready_in low
    ready_in = 1'b0;
    drive(3'd0, 1'b1);
    tick();
    check("bp1_y", y_out, 8'h05);
    check("bp1_ready", ready_out, 1);
    drive(3'd1, 1'b1);
    tick();
    check("bp2_ready", ready_out, 0);
    check("bp2_state", state_out, 2'b11);
    check("bp2_y_held", y_out, 8'h05);
    drive(3'd2, 1'b1);
    tick();
    check("bp3_ready", ready_out, 0);
    check("bp3_valid", valid_out, 1);
    check("bp3_y_held", y_out, 8'h05);
    check("bp3_op_held", op_out, 0);
    check("bp3_count", count_out, 8);
    ready_in = 1'b1;
    tick();
    check("bp_out2_y", y_out, 8'hAF);
    check("bp_out2_ready", ready_out, 1);
    check("bp_out2_count", count_out, 9);
    tick();
    drive(3'd0, 1'b0);
    check("bp_out3_y", y_out, 8'h5A);
    check("bp_out3_count", count_out, 10);
    tick();
    check("bp_count", count_out, 11);
    check("bp_drained", valid_out, 0);

    // Illegal op then legal op
    drive(3'd7, 1'b1);
    tick();
    check("ill_y", y_out, 0);
    check("ill_err", err_out, 1);
    check("ill_op", op_out, 7);
    drive(3'd0, 1'b1);
    tick();
    check("legal_y", y_out, 8'h05);
    check("legal_err", err_out, 0);
    drive(3'd0, 1'b0);
    tick();
    check("ill_count", count_out, 13);
    check("c4_count_13", count_c4, 13);

    // Reset mid-operation with both entries occupied
    ready_in = 1'b0;
    drive(3'd4, 1'b1);
    tick(); tick();
    check("mid_full", state_out, 2'b11);
    #2;
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_ready", ready_out, 0);
    check("mid_rst_count", count_out, 0);
    check("mid_rst_count_c4", count_c4, 0);
    drive(3'd0, 1'b0);
    tick();
    rst_in = 1'b0;
    ready_in = 1'b1;
    #1;
    check("mid_rst_ready_after", ready_out, 1);

    // 17 transfers: 4-bit counter wraps 15 -> 0 and ends at 1
    for (int i = 0; i < 17; i++) begin
      drive(3'(i % 7), 1'b1);
      tick();
      check($sformatf("wrap_y_%0d", i), y_c4, exp_tab[i % 7]);
      check($sformatf("wrap_c4_%0d", i), count_c4, i % 16);
      check($sformatf("wrap_c16_%0d", i), count_out, i);
    end
    drive(3'd0, 1'b0);
    tick();
    check("wrap_c4_end", count_c4, 1);
    check("wrap_c16_end", count_out, 17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
